// File: rtl/ppu_reg_read_port.sv
// CPU read side of the PPU registers: PPUSTATUS, OAMDATA, PPUDATA with read buffer,
// plus the decaying open-bus latch shared by every register access.
module ppu_reg_read_port #(
    parameter int DECAY_CYCLES = 3221591,
    parameter int DECAY_W      = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_rd_valid,
    input  logic        vblank_set,
    input  logic        vblank_clr,
    input  logic        sprite0_hit,
    input  logic        sprite_overflow,
    input  logic [7:0]  oam_rd_data,
    input  logic [13:0] vram_addr,
    input  logic [5:0]  palette_data,
    output logic        write_toggle_clr,
    output logic        vram_addr_inc,
    output logic        vram_rd_req,
    output logic [13:0] vram_rd_addr,
    input  logic        vram_rd_ack,
    input  logic [7:0]  vram_rd_data
);

    localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_CYCLES);
    localparam logic [DECAY_W-1:0] DECAY_ONE  = DECAY_W'(1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t       state_q, state_d;
    logic         vblank_q, vblank_d;
    logic [7:0]   buf_q, buf_d;
    logic [7:0]   ob_q, ob_d;
    logic [DECAY_W-1:0] decay_q, decay_d;
    logic [13:0]  fetch_addr_q, fetch_addr_d;
    logic [7:0]   rd_data_q, rd_data_d;
    logic         rd_valid_q, rd_valid_d;
    logic         wtc_q, wtc_d;
    logic         inc_q, inc_d;

    logic         rd_status, rd_ppudata, is_pal;
    logic [7:0]   ret_byte;

    assign rd_status  = cpu_rd_en && (cpu_addr == 3'd2);
    assign rd_ppudata = cpu_rd_en && (cpu_addr == 3'd7);
    assign is_pal     = (vram_addr >= 14'h3F00);

    // Byte the CPU sees; a vblank_set racing a status read is hidden from bit 7.
    always_comb begin
        ret_byte = ob_q;
        case (cpu_addr)
            3'd2:    ret_byte = {vblank_q & ~vblank_set, sprite0_hit, sprite_overflow, ob_q[4:0]};
            3'd4:    ret_byte = oam_rd_data;
            3'd7:    ret_byte = is_pal ? {ob_q[7:6], palette_data} : buf_q;
            default: ret_byte = ob_q;
        endcase
    end

    always_comb begin
        rd_valid_d = cpu_rd_en;
        rd_data_d  = cpu_rd_en ? ret_byte : 8'h00;
        wtc_d      = rd_status;
        inc_d      = rd_ppudata;

        vblank_d = vblank_q;
        if (rd_status)       vblank_d = 1'b0;
        else if (vblank_clr) vblank_d = 1'b0;
        else if (vblank_set) vblank_d = 1'b1;

        // Reads take priority over a simultaneous write for the open-bus refresh.
        ob_d    = ob_q;
        decay_d = decay_q;
        if (cpu_rd_en) begin
            ob_d    = ret_byte;
            decay_d = DECAY_LOAD;
        end else if (cpu_wr_en) begin
            ob_d    = cpu_wr_data;
            decay_d = DECAY_LOAD;
        end else if (decay_q != '0) begin
            decay_d = decay_q - DECAY_ONE;
            if (decay_q == DECAY_ONE) ob_d = 8'h00;
        end
    end

    // Fetch FSM: next state and the registers it owns.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        buf_d        = buf_q;
        case (state_q)
            IDLE: begin
                if (rd_ppudata) begin
                    state_d      = FETCH;
                    fetch_addr_d = is_pal ? (vram_addr - 14'h1000) : vram_addr;
                end
            end
            FETCH: begin
                if (vram_rd_ack) begin
                    state_d = IDLE;
                    buf_d   = vram_rd_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vram_rd_req  = (state_q == FETCH);
        vram_rd_addr = fetch_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vblank_q     <= 1'b0;
            buf_q        <= 8'h00;
            ob_q         <= 8'h00;
            decay_q      <= '0;
            fetch_addr_q <= 14'h0000;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            wtc_q        <= 1'b0;
            inc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblank_q     <= vblank_d;
            buf_q        <= buf_d;
            ob_q         <= ob_d;
            decay_q      <= decay_d;
            fetch_addr_q <= fetch_addr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wtc_q        <= wtc_d;
            inc_q        <= inc_d;
        end
    end

    assign cpu_rd_data      = rd_data_q;
    assign cpu_rd_valid     = rd_valid_q;
    assign write_toggle_clr = wtc_q;
    assign vram_addr_inc    = inc_q;

endmodule

// File: doc/ppu_reg_read_port.md
Name: ppu_reg_read_port

Overview:
- CPU-facing read side of the PPU register file at 0x2000-0x2007; complements the write-only control registers.
- Returns PPUSTATUS (0x2002), OAMDATA (0x2004) and PPUDATA (0x2007) with their read side effects.
- PPUDATA reads go through a one-byte read buffer, refilled from VRAM by a request/acknowledge handshake.
- Holds the data-bus open-bus latch with decay; all other addresses read back open bus.

Parameters:
- DECAY_CYCLES, 3221591, clk cycles after the last bus refresh before the open-bus latch decays to 0x00 (about 0.6 s at 5.37 MHz).
- DECAY_W, 22, width of the decay counter; must hold DECAY_CYCLES.

Ports:
- clk  in  1  PPU clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd_en  in  1  one-cycle read strobe.
- cpu_wr_en  in  1  one-cycle write strobe (any register); refreshes open bus only.
- cpu_addr  in  3  register index (address bits 2:0).
- cpu_wr_data  in  8  CPU write data.
- cpu_rd_data  out  8  read data.
- cpu_rd_valid  out  1  cpu_rd_data valid, exactly one cycle.
- vblank_set  in  1  pulse from timing at the start of vblank.
- vblank_clr  in  1  pulse from timing at the pre-render line.
- sprite0_hit  in  1  live flag.
- sprite_overflow  in  1  live flag.
- oam_rd_data  in  8  OAM byte at the current OAMADDR.
- vram_addr  in  14  current v register.
- palette_data  in  6  palette RAM entry at vram_addr.
- write_toggle_clr  out  1  pulse; clears the w toggle.
- vram_addr_inc  out  1  pulse; increment v.
- vram_rd_req  out  1  VRAM fetch request, held until ack.
- vram_rd_addr  out  14  fetch address, stable while vram_rd_req is high.
- vram_rd_ack  in  1  fetch complete; vram_rd_data valid this cycle.
- vram_rd_data  in  8  fetched byte.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; vblank flag 0; read buffer 0x00; open-bus latch 0x00; decay counter 0; FSM IDLE.
- Read latency: cpu_rd_valid and cpu_rd_data are registered, asserting the cycle after cpu_rd_en. Side-effect pulses occur in that same cycle.
- If cpu_rd_en and cpu_wr_en are both high, the read wins and the write is ignored.
- 0x2002 read:
  - data = {vblank_flag, sprite0_hit, sprite_overflow, open_bus[4:0]}.
  - Clears vblank_flag and pulses write_toggle_clr.
  - If vblank_set coincides with the read cycle: bit7 returns 0 and the flag stays clear (suppression).
- vblank_flag: set on vblank_set, cleared on vblank_clr. If both pulse together, vblank_clr wins.
- 0x2004 read: data = oam_rd_data; no side effect.
- 0x2007 read, vram_addr < 0x3F00:
  - data = read buffer.
  - Pulses vram_addr_inc.
  - If FSM is IDLE, FSM goes to FETCH with vram_rd_addr = vram_addr.
- 0x2007 read, vram_addr >= 0x3F00:
  - data = {open_bus[7:6], palette_data}.
  - Pulses vram_addr_inc.
  - If FSM is IDLE, the buffer refill uses vram_rd_addr = vram_addr - 0x1000 (nametable underneath).
- 0x2007 read while FSM is in FETCH: returns the current (stale) buffer and pulses vram_addr_inc; the outstanding fetch is not restarted and no extra fetch is queued.
- Other indices (0, 1, 3, 5, 6): data = open_bus; no side effect.
- FSM:
  - IDLE -> FETCH on an accepted PPUDATA read.
  - FETCH: vram_rd_req=1, vram_rd_addr latched and stable.
  - On vram_rd_ack: buffer <= vram_rd_data, vram_rd_req drops the next cycle, FSM -> IDLE.
  - An ack in the same cycle as a new 0x2007 read: the read returns the old buffer, the buffer takes the ack data, and no new fetch is issued.
  - An ack while IDLE is ignored.
- Open bus:
  - Any write loads cpu_wr_data; any read loads the returned byte.
  - Either event reloads the decay counter with DECAY_CYCLES.
  - Counter decrements each cycle while nonzero; the transition 1 -> 0 clears the latch to 0x00.
  - While the counter is 0 the latch holds 0x00.
- Reset mid-fetch: vram_rd_req drops asynchronously; buffer returns to 0x00.

Test Plan:
- Reset, then read 0x2002 -> rd_data=0x00 one cycle later; write_toggle_clr pulses once; rd_valid high exactly 1 cycle.
- vblank_set pulse, then read 0x2002 with sprite0_hit=1 after writing 0x1F to 0x2000 -> rd_data=0xDF; a second 0x2002 read -> 0x5F.
- vblank_set in the same cycle as a 0x2002 read -> bit7=0; a following read also shows bit7=0.
- vram_addr=0x2000, ack after 3 cycles with 0xAB: first 0x2007 read -> 0x00; vram_rd_req held 3 cycles at addr 0x2000; second read (vram_addr=0x2001) -> 0xAB; two vram_addr_inc pulses total.
- vram_addr=0x3F05, palette_data=0x2A, open_bus=0xC0 -> rd_data=0xEA; fetch issued at 0x2F05.
- DECAY_CYCLES=16: write 0x5A to 0x2000, then read 0x2005 at cycle 10 -> 0x5A; read 0x2005 again at cycle 10+17 -> 0x00.
